dmem_arbiter: RTL and testbench

//   Shares the single data-memory / MMIO port (RAM + LED/digit/UART registers at 0x4000_00xx) between two requesters:
//   m0 = CPU load/store unit, m1 = UART loader/DMA engine. Registered two-phase FSM: arbitrate, then one access cycle.

---
 rtl/dmem_arbiter_pkg.sv | 18 +
 rtl/dmem_addr_check.sv | 24 ++
 rtl/dmem_arbiter.sv | 115 +++++++++++
 tb/tb_dmem_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter, memory map decoder and loader.
// Holds FSM states, requester ids and the MMIO window geometry.
package dmem_arbiter_pkg;

    localparam logic [31:0] PERIPH_BASE = 32'h4000_0000;
    localparam logic [31:0] MMIO_BYTES  = 32'd64;

    typedef enum logic {
        ST_IDLE,
        ST_ACCESS
    } state_t;

    typedef enum logic {
        OWN_M0,
        OWN_M1
    } owner_t;

endpackage

// File: rtl/dmem_addr_check.sv
// Combinational legality check for a data-port address.
// Legal: word aligned and inside RAM or the MMIO window.
module dmem_addr_check #(
    parameter int          RAM_SIZE    = 256,
    parameter logic [31:0] PERIPH_BASE = dmem_arbiter_pkg::PERIPH_BASE
) (
    input  logic [31:0] addr,
    output logic        bad
);
    import dmem_arbiter_pkg::*;

    localparam logic [31:0] RAM_BYTES  = 32'(RAM_SIZE * 4);
    localparam logic [31:0] PERIPH_END = PERIPH_BASE + MMIO_BYTES;

    logic aligned;
    logic in_ram;
    logic in_mmio;

    assign aligned = (addr[1:0] == 2'b00);
    assign in_ram  = (addr < RAM_BYTES);
    assign in_mmio = (addr >= PERIPH_BASE) && (addr < PERIPH_END);
    assign bad     = !aligned || !(in_ram || in_mmio);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for the data-memory / MMIO port.
// m0 has priority; a streak counter forces an m1 grant after FAIR_LIMIT wins.
module dmem_arbiter #(
    parameter int          RAM_SIZE    = 256,
    parameter int          FAIR_LIMIT  = 4,
    parameter logic [31:0] PERIPH_BASE = dmem_arbiter_pkg::PERIPH_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] rdata,
    output logic        err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [31:0] mem_rdata
);
    import dmem_arbiter_pkg::*;

    localparam int            SW    = $clog2(FAIR_LIMIT + 1);
    localparam logic [SW-1:0] LIMIT = SW'(FAIR_LIMIT);

    state_t        state;
    owner_t        owner;
    logic          bad_q;
    logic [SW-1:0] streak;

    logic          pick_m1;
    logic          sel_we;
    logic [31:0]   sel_addr;
    logic [31:0]   sel_wdata;
    logic          sel_bad;

    assign pick_m1   = m1_req && (!m0_req || streak == LIMIT);
    assign sel_we    = pick_m1 ? m1_we    : m0_we;
    assign sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    assign sel_wdata = pick_m1 ? m1_wdata : m0_wdata;

    dmem_addr_check #(
        .RAM_SIZE    (RAM_SIZE),
        .PERIPH_BASE (PERIPH_BASE)
    ) u_addr_check (
        .addr (sel_addr),
        .bad  (sel_bad)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            owner     <= OWN_M0;
            bad_q     <= 1'b0;
            streak    <= '0;
            m0_gnt    <= 1'b0;
            m1_gnt    <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            rdata     <= '0;
            err       <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (m0_req || m1_req) begin
                        state     <= ST_ACCESS;
                        owner     <= pick_m1 ? OWN_M1 : OWN_M0;
                        bad_q     <= sel_bad;
                        mem_addr  <= sel_addr;
                        mem_wdata <= sel_wdata;
                        mem_read  <= !sel_we && !sel_bad;
                        mem_write <= sel_we && !sel_bad;
                        m0_gnt    <= !pick_m1;
                        m1_gnt    <= pick_m1;
                        // streak only grows while m1 is actually waiting
                        if (!pick_m1 && m1_req) begin
                            if (streak != LIMIT) begin
                                streak <= streak + SW'(1);
                            end
                        end else begin
                            streak <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    state     <= ST_IDLE;
                    m0_gnt    <= 1'b0;
                    m1_gnt    <= 1'b0;
                    mem_read  <= 1'b0;
                    mem_write <= 1'b0;
                    m0_rvalid <= (owner == OWN_M0);
                    m1_rvalid <= (owner == OWN_M1);
                    rdata     <= mem_read ? mem_rdata : '0;
                    err       <= bad_q;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural RAM/MMIO model.
// Directed requests push expected responses; a negedge monitor checks them.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        err, mem_read, mem_write;

    typedef struct packed {
        logic        own;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    logic [31:0] ram  [0:255];
    logic [31:0] mmio [0:15];
    logic        g_read, g_write;
    logic [31:0] g_addr, g_wdata;

    dmem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd1024) ? ram[mem_addr[9:2]]
                                             : mmio[mem_addr[5:2]];

    always @(posedge clk) begin
        if (mem_write) begin
            wr_cnt <= wr_cnt + 1;
            if (mem_addr < 32'd1024) ram[mem_addr[9:2]] <= mem_wdata;
            else mmio[mem_addr[5:2]] <= mem_wdata;
        end
        if (mem_read) rd_cnt <= rd_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (reset && (m0_rvalid || m1_rvalid)) begin
            if (m0_rvalid && m1_rvalid) begin
                checks++;
                errors++;
                $display("FAIL both_rvalid: got 11 want one-hot");
            end else if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rvalid: got m1=%0b want none",
                         m1_rvalid);
            end else begin
                mon_e = sb.pop_front();
                check("resp_owner", 32'(m1_rvalid), 32'(mon_e.own));
                check("resp_rdata", rdata, mon_e.rdata);
                check("resp_err", 32'(err), 32'(mon_e.err));
            end
        end
    end

    task automatic do_req(input bit m, input bit we, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] er,
                          input bit ee, output int n);
        sb.push_back('{own: m, rdata: er, err: ee});
        if (!m) begin
            m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
        end else begin
            m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
        end
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(m ? m1_gnt : m0_gnt) && n < 8);
        check("gnt_seen", 32'(m ? m1_gnt : m0_gnt), 32'd1);
        g_read  = mem_read;
        g_write = mem_write;
        g_addr  = mem_addr;
        g_wdata = mem_wdata;
        m0_req  = 1'b0;
        m1_req  = 1'b0;
        @(posedge clk); #1;
        check("rvalid_next", 32'(m ? m1_rvalid : m0_rvalid), 32'd1);
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctl"},
              32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, err,
                   mem_read, mem_write}), 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
        check({tag, "_maddr"}, mem_addr, 32'd0);
        check({tag, "_mwdata"}, mem_wdata, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int c;
        int k;
        int last;
        bit seq [10];

        reset = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        for (int i = 0; i < 256; i++) ram[i] = 32'(i) * 32'h0101_0101;
        for (int i = 0; i < 16; i++) mmio[i] = '0;
        ram[4] = 32'hDEAD_BEEF;
        ram[5] = 32'h1234_5678;
        ram[8] = 32'h1111_1111;
        repeat (2) @(posedge clk);
        #1;
        check_zero("por");
        reset = 1'b1;
        @(posedge clk); #1;

        // 1: read latency, then reset mid-run clears everything
        do_req(0, 0, 32'h10, 32'h0, 32'hDEAD_BEEF, 0, n);
        check("t1_latency", 32'(n), 32'd1);
        @(posedge clk); #1;
        check("t1_rdata_held", rdata, 32'hDEAD_BEEF);
        reset = 1'b0;
        #1;
        check_zero("midrst");
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // 2: MMIO write
        do_req(0, 1, 32'h4000_000C, 32'hA5, 32'h0, 0, n);
        check("t2_write", 32'(g_write), 32'd1);
        check("t2_read", 32'(g_read), 32'd0);
        check("t2_addr", g_addr, 32'h4000_000C);
        check("t2_wdata", g_wdata, 32'hA5);
        check("t2_mmio", mmio[3], 32'hA5);

        // 3: fairness with both requesters held
        for (int i = 0; i < 10; i++) begin
            seq[i] = (i % 5 == 4);
            sb.push_back('{own: seq[i],
                           rdata: seq[i] ? 32'h1234_5678 : 32'hDEAD_BEEF,
                           err: 1'b0});
        end
        m0_we = 0; m0_addr = 32'h10;
        m1_we = 0; m1_addr = 32'h14;
        m0_req = 1; m1_req = 1;
        k = 0;
        for (int cyc = 0; cyc < 40 && k < 10; cyc++) begin
            @(posedge clk); #1;
            if (m0_gnt || m1_gnt) begin
                check("t3_gnt_m1", 32'(m1_gnt), 32'(seq[k]));
                k++;
                if (k == 10) begin
                    m0_req = 0; m1_req = 0;
                end
            end
        end
        m0_req = 0; m1_req = 0;
        check("t3_count", 32'(k), 32'd10);
        repeat (2) @(posedge clk);
        #1;

        // 4: illegal m1 reads
        c = rd_cnt;
        do_req(1, 0, 32'h402, 32'h0, 32'h0, 1, n);
        check("t4a_read", 32'(g_read), 32'd0);
        do_req(1, 0, 32'h400, 32'h0, 32'h0, 1, n);
        check("t4b_read", 32'(g_read), 32'd0);
        check("t4_rdcnt", 32'(rd_cnt), 32'(c));

        // 5: reset during a write access
        c = wr_cnt;
        m0_we = 1; m0_addr = 32'h20; m0_wdata = 32'hCAFE; m0_req = 1;
        @(posedge clk); #1;
        check("t5_gnt", 32'(m0_gnt), 32'd1);
        check("t5_wr_pre", 32'(mem_write), 32'd1);
        reset = 1'b0;
        #1;
        check("t5_wr_drop", 32'(mem_write), 32'd0);
        m0_req = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("t5_ram8", ram[8], 32'h1111_1111);
        check("t5_wrcnt", 32'(wr_cnt), 32'(c));

        // 6: back-to-back m0 reads
        for (int i = 0; i < 4; i++)
            sb.push_back('{own: 1'b0, rdata: 32'h1234_5678, err: 1'b0});
        m0_we = 0; m0_addr = 32'h14; m0_req = 1;
        k = 0;
        last = 0;
        for (int cyc = 0; cyc < 30 && k < 4; cyc++) begin
            @(posedge clk); #1;
            if (m0_gnt) begin
                if (k > 0) check("t6_gap", 32'(cyc - last), 32'd2);
                last = cyc;
                k++;
                if (k == 4) m0_req = 0;
            end
        end
        m0_req = 0;
        check("t6_count", 32'(k), 32'd4);

        for (int i = 0; i < 10 && sb.size() != 0; i++) begin
            @(posedge clk); #1;
        end
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
